// File: rtl/ctrl_redirect_unit.sv
// ============================================================================
// Module   : ctrl_redirect_unit
// Brief    : Control-ALU back end. It holds one pending fetch redirect, with a
//            valid/ready handshake toward fetch, and a 2-entry buffer of CSR
//            writes that drain to the CSR file as each write commits.
// Option   : REDIRECT_AGE_ORDER_EN -- when defined, an older mispredict that
//            arrives while a redirect is pending replaces the pending one.
//            When undefined, such a mispredict is stalled until the
//            handshake completes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 6
`endif
`ifndef CSR_WIDTH_LOG
`define CSR_WIDTH_LOG 12
`endif
`ifndef CSR_WIDTH
`define CSR_WIDTH 32
`endif

module ctrl_redirect_unit (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            ctrlValid_i,
    input  logic [`SIZE_PC-1:0]             ctrlNextPC_i,
    input  logic                            ctrlMispredict_i,
    input  logic [`SIZE_ACTIVELIST_LOG-1:0] ctrlALid_i,
    input  logic                            ctrlCsrWrEn_i,
    input  logic [`CSR_WIDTH_LOG-1:0]       ctrlCsrWrAddr_i,
    input  logic [`CSR_WIDTH-1:0]           ctrlCsrWrData_i,
    input  logic [`SIZE_ACTIVELIST_LOG-1:0] alHead_i,
    input  logic                            recoverFlag_i,
    input  logic                            redirectReady_i,
    input  logic                            csrCommit_i,
    output logic                            ctrlStall_o,
    output logic                            redirectValid_o,
    output logic [`SIZE_PC-1:0]             redirectPC_o,
    output logic [`SIZE_ACTIVELIST_LOG-1:0] redirectALid_o,
    output logic                            csrWrEn_o,
    output logic [`CSR_WIDTH_LOG-1:0]       csrWrAddr_o,
    output logic [`CSR_WIDTH-1:0]           csrWrData_o
);

    localparam int PC_W = `SIZE_PC;
    localparam int AL_W = `SIZE_ACTIVELIST_LOG;
    localparam int CA_W = `CSR_WIDTH_LOG;
    localparam int CD_W = `CSR_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [PC_W-1:0]            pc_q, pc_d;
    logic [AL_W-1:0]            alid_q, alid_d;

    logic [1:0][CA_W-1:0]       fifo_addr_q, fifo_addr_d;
    logic [1:0][CD_W-1:0]       fifo_data_q, fifo_data_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic [1:0]                 count_q, count_d;

    logic                       fifo_full;
    logic                       fifo_nonempty;
    logic                       pop;
    logic                       push;
    logic                       handshake;
    logic                       stall;
    logic                       accept;

`ifdef REDIRECT_AGE_ORDER_EN
    logic [AL_W-1:0]            new_age;
    logic [AL_W-1:0]            pend_age;

    // Age relative to the active-list head; wraps naturally in AL_W bits.
    always_comb begin
        new_age  = ctrlALid_i - alHead_i;
        pend_age = alid_q - alHead_i;
    end
`else
    // The head pointer only matters when age ordering is built in.
    logic                       unused_al_head;
    assign unused_al_head = ^alHead_i;
`endif

    // Handshake, pop, back-pressure and acceptance qualifiers.
    always_comb begin
        fifo_full     = (count_q == 2'd2);
        fifo_nonempty = (count_q != 2'd0);
        pop           = csrCommit_i & fifo_nonempty;
        handshake     = (state_q == ST_PEND) & redirectReady_i;
        // A pop on the same edge frees a slot, so a full buffer only stalls
        // when nothing drains this cycle.
        stall         = fifo_full & ~pop;
`ifndef REDIRECT_AGE_ORDER_EN
        // Without age ordering a second mispredict cannot be held; hold it
        // off until fetch takes the pending redirect.
        stall         = stall | ((state_q == ST_PEND) & ~redirectReady_i &
                                 ctrlValid_i & ctrlMispredict_i);
`endif
        accept        = ctrlValid_i & ~stall & ~recoverFlag_i;
        push          = accept & ctrlCsrWrEn_i;
    end

    // Redirect FSM next-state and target latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        alid_d  = alid_q;
        if (recoverFlag_i) begin
            state_d = ST_IDLE;
        end else begin
            if (handshake) begin
                state_d = ST_IDLE;
            end
            if (accept && ctrlMispredict_i) begin
                if ((state_q == ST_IDLE) || handshake) begin
                    state_d = ST_PEND;
                    pc_d    = ctrlNextPC_i;
                    alid_d  = ctrlALid_i;
                end
`ifdef REDIRECT_AGE_ORDER_EN
                else if (new_age < pend_age) begin
                    pc_d    = ctrlNextPC_i;
                    alid_d  = ctrlALid_i;
                end
`endif
            end
        end
    end

    // CSR write buffer: push at the write pointer, pop at the read pointer.
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (recoverFlag_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                fifo_addr_d[wr_ptr_q] = ctrlCsrWrAddr_i;
                fifo_data_d[wr_ptr_q] = ctrlCsrWrData_i;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            alid_q      <= '0;
            fifo_addr_q <= '0;
            fifo_data_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            alid_q      <= alid_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Outputs; the CSR head is masked while empty so reset reads as zero.
    always_comb begin
        ctrlStall_o     = stall;
        redirectValid_o = (state_q == ST_PEND);
        redirectPC_o    = pc_q;
        redirectALid_o  = alid_q;
        csrWrEn_o       = pop;
        csrWrAddr_o     = fifo_nonempty ? fifo_addr_q[rd_ptr_q] : '0;
        csrWrData_o     = fifo_nonempty ? fifo_data_q[rd_ptr_q] : '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_redirect_unit.sv
// ============================================================================
// Module   : tb_ctrl_redirect_unit
// Brief    : Self-checking bench for ctrl_redirect_unit. Vector tables hold
//            per-cycle inputs and the outputs expected in that cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 6
`endif
`ifndef CSR_WIDTH_LOG
`define CSR_WIDTH_LOG 12
`endif
`ifndef CSR_WIDTH
`define CSR_WIDTH 32
`endif

module tb_ctrl_redirect_unit;

`ifdef REDIRECT_AGE_ORDER_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif
    localparam int OUT_W = 1 + 1 + `SIZE_PC + `SIZE_ACTIVELIST_LOG + 1 + `CSR_WIDTH_LOG + `CSR_WIDTH;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        mp;
        logic [5:0]  al;
        logic        cwe;
        logic [11:0] ca;
        logic [31:0] cd;
        logic [5:0]  head;
        logic        rec;
        logic        rdy;
        logic        com;
    } in_t;

    typedef struct {
        in_t              i;
        logic [OUT_W-1:0] o;
    } vec_t;

    logic                            clk;
    logic                            reset_n;
    logic                            ctrlValid_i;
    logic [`SIZE_PC-1:0]             ctrlNextPC_i;
    logic                            ctrlMispredict_i;
    logic [`SIZE_ACTIVELIST_LOG-1:0] ctrlALid_i;
    logic                            ctrlCsrWrEn_i;
    logic [`CSR_WIDTH_LOG-1:0]       ctrlCsrWrAddr_i;
    logic [`CSR_WIDTH-1:0]           ctrlCsrWrData_i;
    logic [`SIZE_ACTIVELIST_LOG-1:0] alHead_i;
    logic                            recoverFlag_i;
    logic                            redirectReady_i;
    logic                            csrCommit_i;
    logic                            ctrlStall_o;
    logic                            redirectValid_o;
    logic [`SIZE_PC-1:0]             redirectPC_o;
    logic [`SIZE_ACTIVELIST_LOG-1:0] redirectALid_o;
    logic                            csrWrEn_o;
    logic [`CSR_WIDTH_LOG-1:0]       csrWrAddr_o;
    logic [`CSR_WIDTH-1:0]           csrWrData_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [OUT_W-1:0] sb_q[$];
    vec_t seq_a[$];
    vec_t seq_b[$];
    vec_t seq_c[$];
    vec_t seq_d[$];

    ctrl_redirect_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ctrlValid_i      (ctrlValid_i),
        .ctrlNextPC_i     (ctrlNextPC_i),
        .ctrlMispredict_i (ctrlMispredict_i),
        .ctrlALid_i       (ctrlALid_i),
        .ctrlCsrWrEn_i    (ctrlCsrWrEn_i),
        .ctrlCsrWrAddr_i  (ctrlCsrWrAddr_i),
        .ctrlCsrWrData_i  (ctrlCsrWrData_i),
        .alHead_i         (alHead_i),
        .recoverFlag_i    (recoverFlag_i),
        .redirectReady_i  (redirectReady_i),
        .csrCommit_i      (csrCommit_i),
        .ctrlStall_o      (ctrlStall_o),
        .redirectValid_o  (redirectValid_o),
        .redirectPC_o     (redirectPC_o),
        .redirectALid_o   (redirectALid_o),
        .csrWrEn_o        (csrWrEn_o),
        .csrWrAddr_o      (csrWrAddr_o),
        .csrWrData_o      (csrWrData_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t I(logic v, logic [31:0] pc, logic mp, logic [5:0] al,
                              logic cwe, logic [11:0] ca, logic [31:0] cd,
                              logic [5:0] head, logic rec, logic rdy, logic com);
        in_t r;
        r.v = v; r.pc = pc; r.mp = mp; r.al = al; r.cwe = cwe; r.ca = ca;
        r.cd = cd; r.head = head; r.rec = rec; r.rdy = rdy; r.com = com;
        return r;
    endfunction

    // Expected outputs in port order: stall, rv, pc, alid, we, waddr, wdata.
    function automatic logic [OUT_W-1:0] O(logic st, logic rv, logic [31:0] pc, logic [5:0] al,
                                           logic we, logic [11:0] wa, logic [31:0] wd);
        return {st, rv, pc, al, we, wa, wd};
    endfunction

    function automatic vec_t V(in_t i, logic [OUT_W-1:0] o);
        vec_t r;
        r.i = i;
        r.o = o;
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] dut_out();
        return {ctrlStall_o, redirectValid_o, redirectPC_o, redirectALid_o,
                csrWrEn_o, csrWrAddr_o, csrWrData_o};
    endfunction

    task automatic check(string name, logic [OUT_W-1:0] act, logic [OUT_W-1:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got {stall,rv,pc,al,we,wa,wd}=%h required %h", name, act, exp);
        end
    endtask

    task automatic drive(in_t i);
        ctrlValid_i      = i.v;
        ctrlNextPC_i     = i.pc;
        ctrlMispredict_i = i.mp;
        ctrlALid_i       = i.al;
        ctrlCsrWrEn_i    = i.cwe;
        ctrlCsrWrAddr_i  = i.ca;
        ctrlCsrWrData_i  = i.cd;
        alHead_i         = i.head;
        recoverFlag_i    = i.rec;
        redirectReady_i  = i.rdy;
        csrCommit_i      = i.com;
    endtask

    task automatic do_reset(string name);
        drive(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(name, dut_out(), O(0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
    endtask

    // Drive one vector after the edge, queue its expectation, compare mid-cycle.
    task automatic run_seq(string tag, input vec_t s[$]);
        logic [OUT_W-1:0] exp;
        foreach (s[k]) begin
            @(posedge clk);
            #1;
            drive(s[k].i);
            sb_q.push_back(s[k].o);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                n_cmp  = n_cmp + 1;
                n_fail = n_fail + 1;
                $display("FAIL %s%0d: scoreboard empty", tag, k);
            end else begin
                exp = sb_q.pop_front();
                check($sformatf("%s%0d", tag, k), dut_out(), exp);
            end
        end
    endtask

    initial begin
        logic [31:0] d3_pc;
        logic [5:0]  d3_al;
        logic        d_st;

        // Mispredict held for three not-ready cycles, then accepted by fetch.
        seq_a.push_back(V(I(1, 32'h1040, 1, 5, 0, 0, 0, 0, 0, 0, 0), O(0, 0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 3; k++)
            seq_a.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O(0, 1, 32'h1040, 5, 0, 0, 0)));
        seq_a.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O(0, 1, 32'h1040, 5, 0, 0, 0)));
        seq_a.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O(0, 0, 32'h1040, 5, 0, 0, 0)));

        // CSR buffer: fill, stall, push-with-pop when full, drain, underflow, wrap.
        seq_b.push_back(V(I(1, 0, 0, 0, 1, 12'h001, 32'hA, 0, 0, 0, 0), O(0, 0, 0, 0, 0, 0, 0)));
        seq_b.push_back(V(I(1, 0, 0, 0, 1, 12'h002, 32'hB, 0, 0, 0, 0), O(0, 0, 0, 0, 0, 12'h001, 32'hA)));
        seq_b.push_back(V(I(1, 0, 0, 0, 1, 12'h003, 32'hC, 0, 0, 0, 0), O(1, 0, 0, 0, 0, 12'h001, 32'hA)));
        seq_b.push_back(V(I(1, 0, 0, 0, 1, 12'h003, 32'hC, 0, 0, 0, 0), O(1, 0, 0, 0, 0, 12'h001, 32'hA)));
        seq_b.push_back(V(I(1, 0, 0, 0, 1, 12'h003, 32'hC, 0, 0, 0, 1), O(0, 0, 0, 0, 1, 12'h001, 32'hA)));
        seq_b.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O(1, 0, 0, 0, 0, 12'h002, 32'hB)));
        seq_b.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O(0, 0, 0, 0, 1, 12'h002, 32'hB)));
        seq_b.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O(0, 0, 0, 0, 1, 12'h003, 32'hC)));
        seq_b.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O(0, 0, 0, 0, 0, 0, 0)));
        seq_b.push_back(V(I(1, 0, 0, 0, 1, 12'h004, 32'hD, 0, 0, 0, 0), O(0, 0, 0, 0, 0, 0, 0)));
        seq_b.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O(0, 0, 0, 0, 1, 12'h004, 32'hD)));
        seq_b.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O(0, 0, 0, 0, 0, 0, 0)));

        // Mispredict plus CSR write, then recover flushes both and drops input.
        seq_c.push_back(V(I(1, 32'h2000, 1, 7, 1, 12'h005, 32'h55, 0, 0, 0, 0), O(0, 0, 0, 0, 0, 0, 0)));
        seq_c.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O(0, 1, 32'h2000, 7, 0, 12'h005, 32'h55)));
        seq_c.push_back(V(I(1, 0, 0, 0, 1, 12'h009, 32'h99, 0, 1, 0, 0), O(0, 1, 32'h2000, 7, 0, 12'h005, 32'h55)));
        seq_c.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O(0, 0, 32'h2000, 7, 0, 0, 0)));
        seq_c.push_back(V(I(1, 0, 0, 0, 1, 12'h006, 32'h66, 0, 0, 0, 0), O(0, 0, 32'h2000, 7, 0, 0, 0)));
        seq_c.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), O(0, 0, 32'h2000, 7, 1, 12'h006, 32'h66)));
        seq_c.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O(0, 0, 32'h2000, 7, 0, 0, 0)));

        // Age ordering around a wrapped head: pending age 6, newcomer age 2.
        d_st  = AGE_EN ? 1'b0 : 1'b1;
        d3_pc = AGE_EN ? 32'h4000 : 32'h3000;
        d3_al = AGE_EN ? 6'd62 : 6'd2;
        seq_d.push_back(V(I(1, 32'h3000, 1, 2, 0, 0, 0, 60, 0, 0, 0), O(0, 0, 0, 0, 0, 0, 0)));
        seq_d.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 60, 0, 0, 0), O(0, 1, 32'h3000, 2, 0, 0, 0)));
        seq_d.push_back(V(I(1, 32'h4000, 1, 62, 0, 0, 0, 60, 0, 0, 0), O(d_st, 1, 32'h3000, 2, 0, 0, 0)));
        seq_d.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 60, 0, 0, 0), O(0, 1, d3_pc, d3_al, 0, 0, 0)));
        seq_d.push_back(V(I(1, 32'h5000, 1, 10, 0, 0, 0, 60, 0, 0, 0), O(d_st, 1, d3_pc, d3_al, 0, 0, 0)));
        seq_d.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 60, 0, 0, 0), O(0, 1, d3_pc, d3_al, 0, 0, 0)));
        seq_d.push_back(V(I(1, 32'h6000, 1, 20, 0, 0, 0, 60, 0, 1, 0), O(0, 1, d3_pc, d3_al, 0, 0, 0)));
        seq_d.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 60, 0, 0, 0), O(0, 1, 32'h6000, 20, 0, 0, 0)));
        seq_d.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 60, 0, 1, 0), O(0, 1, 32'h6000, 20, 0, 0, 0)));
        seq_d.push_back(V(I(0, 0, 0, 0, 0, 0, 0, 60, 0, 0, 0), O(0, 0, 32'h6000, 20, 0, 0, 0)));

        reset_n = 1'b1;
        drive(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_initial", dut_out(), O(0, 0, 0, 0, 0, 0, 0));

        do_reset("rst_a");
        run_seq("redir_a", seq_a);
        do_reset("rst_b");
        run_seq("csr_b", seq_b);
        do_reset("rst_c");
        run_seq("recover_c", seq_c);
        do_reset("rst_d");
        run_seq("age_d", seq_d);

        // Asynchronous reset between edges while a redirect and a CSR write pend.
        do_reset("rst_e");
        @(posedge clk);
        #1;
        drive(I(1, 32'h7000, 1, 3, 1, 12'h00E, 32'hEE, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(I(1, 32'h8000, 1, 4, 0, 0, 0, 0, 0, 0, 1));
        #1;
        check("async_pre", dut_out(),
              O(AGE_EN ? 1'b0 : 1'b1, 1, 32'h7000, 3, 1, 12'h00E, 32'hEE));
        #1;
        reset_n = 1'b0;
        #1;
        check("async_imm", dut_out(), O(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("async_hold", dut_out(), O(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("async_edge", dut_out(), O(0, 0, 0, 0, 0, 0, 0));
        drive(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        @(posedge clk);

        if (sb_q.size() != 0) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
